console_input: RTL

- Memory-mapped character source on the CPU data bus; the read-side counterpart of the character-print/stop sink at word address 0.
- Bytes arrive on a valid/ready stream and are buffered in a FIFO. The CPU reads them one at a time from the DATA register, with the character in lane [15:8].
- An empty read returns 0 in [15:8], the same 0-means-end convention the print sink uses.
- Used in simulation and on hardware, fed by a testbench byte source or a UART receiver.

---
 rtl/console_input_if.sv | 22 ++
 rtl/console_input.sv | 115 +++++++++++
 2 files changed

// File: rtl/console_input_if.sv
// Byte stream feeding the console input FIFO.
// Latency: none, plain wires between producer and FIFO.
// Backpressure: producer holds rx_data/rx_valid until a rising edge with rx_ready high.
interface console_input_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  // Producer side (testbench byte source or UART receiver).
  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready
  );

  // FIFO side.
  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready
  );
endinterface

// File: rtl/console_input.sv
// CPU-readable character FIFO: DATA at BASE_ADDR (char in [15:8]), STATUS at BASE_ADDR+1.
// Latency: bus read data is combinational; a byte accepted on an edge is readable the next cycle.
// Backpressure: rx_ready low when the FIFO is full or a flush write is on the bus; nothing is dropped.
module console_input #(
  parameter logic [29:0] BASE_ADDR = 30'h1,
  // DEPTH must equal 2**PTR_W (2..128) so the pointers wrap naturally.
  parameter int          DEPTH     = 16,
  parameter int          PTR_W     = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [29:0]   data_address,
  inout  wire  [31:0]   data_bus,
  input  logic          data_cs,
  input  logic          data_rw,
  input  logic [1:0]    data_mode,
  console_input_if.slave rx
);

  localparam logic [PTR_W:0] FULL_CNT  = (PTR_W+1)'(DEPTH);
  localparam logic [29:0]    STAT_ADDR = BASE_ADDR + 30'd1;

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;
  logic             rd_prev;

  logic             sel_data;
  logic             sel_stat;
  logic             rd_data;
  logic             rd_stat;
  logic             flush_wr;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;
  logic [7:0]       head_byte;
  logic [31:0]      rd_word;
  logic             drive_en;
  logic             unused_bits;

  // Access size is irrelevant (everything is a word access) and only bit 0
  // of a write matters; fold the rest away.
  assign unused_bits = ^{data_mode, data_bus[31:1]};

  // Address decode and access classification.
  always_comb begin
    sel_data = data_cs && (data_address == BASE_ADDR);
    sel_stat = data_cs && (data_address == STAT_ADDR);
    rd_data  = sel_data && !data_rw;
    rd_stat  = sel_stat && !data_rw;
    flush_wr = sel_stat && data_rw && data_bus[0];
  end

  // FIFO status and handshake decisions for this edge.
  always_comb begin
    empty       = (count == '0);
    full        = (count == FULL_CNT);
    rx.rx_ready = !full && !flush_wr;
    push        = rx.rx_valid && rx.rx_ready;
    // Pop on the first edge after a DATA read ends, so the character stays
    // stable for the whole access. A flush on the same edge wins.
    pop         = rd_prev && !rd_data && !empty && !flush_wr;
    head_byte   = empty ? 8'h00 : mem[head];
  end

  // Read data mux; the bus is released for writes and unselected cycles.
  always_comb begin
    rd_word  = 32'h0;
    drive_en = 1'b0;
    if (rd_data) begin
      rd_word  = {16'h0, head_byte, 7'h0, !empty};
      drive_en = 1'b1;
    end else if (rd_stat) begin
      rd_word  = {8'h0, 8'(count), 14'h0, full, !empty};
      drive_en = 1'b1;
    end
  end

  assign data_bus = drive_en ? rd_word : 32'bz;

  // Storage write at the tail; contents are never cleared, only pointers.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[tail] <= rx.rx_data;
    end
  end

  // Pointers, occupancy and read-end tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      rd_prev <= 1'b0;
    end else begin
      rd_prev <= rd_data;
      if (flush_wr) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) begin
          tail <= tail + 1'b1;
        end
        if (pop) begin
          head <= head + 1'b1;
        end
        count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
      end
    end
  end

endmodule
